// File: rtl/icap_reboot_ctrl_if.sv
// ---------------------------------------------------------------------------
// icap_reboot_ctrl_if
// Bundles the request/status handshake and the ICAP_SPARTAN6 write port of
// icap_reboot_ctrl into one interface.
//   reboot_req  : single-cycle reboot request
//   boot_sel    : 0 = built-in boot address, 1 = boot_addr
//   boot_addr   : runtime boot address (ADDR_W bits)
//   busy / done : controller progress status
//   icap_ce_n / icap_write_n / icap_din : ICAP write port (active-low strobes)
//   icap_busy   : ICAP BUSY back-pressure
//   wdt_kick / wdt_expired : watchdog, only with ICAP_REBOOT_WDT_EN defined
// Modports: slave = controller side, master = supervisor + ICAP side.
// ---------------------------------------------------------------------------
interface icap_reboot_ctrl_if #(
  parameter int unsigned ADDR_W = 24
) ();
  logic              reboot_req;
  logic              boot_sel;
  logic [ADDR_W-1:0] boot_addr;
  logic              busy;
  logic              done;
  logic              icap_ce_n;
  logic              icap_write_n;
  logic [15:0]       icap_din;
  logic              icap_busy;
`ifdef ICAP_REBOOT_WDT_EN
  logic              wdt_kick;
  logic              wdt_expired;

  modport slave (
    input  reboot_req, boot_sel, boot_addr, icap_busy, wdt_kick,
    output busy, done, icap_ce_n, icap_write_n, icap_din, wdt_expired
  );

  modport master (
    output reboot_req, boot_sel, boot_addr, icap_busy, wdt_kick,
    input  busy, done, icap_ce_n, icap_write_n, icap_din, wdt_expired
  );
`else
  modport slave (
    input  reboot_req, boot_sel, boot_addr, icap_busy,
    output busy, done, icap_ce_n, icap_write_n, icap_din
  );

  modport master (
    output reboot_req, boot_sel, boot_addr, icap_busy,
    input  busy, done, icap_ce_n, icap_write_n, icap_din
  );
`endif
endinterface

// File: rtl/icap_reboot_ctrl.sv
// ---------------------------------------------------------------------------
// icap_reboot_ctrl
// Streams the Spartan-6 IPROG multiboot command sequence (16 words) into an
// externally instantiated ICAP_SPARTAN6 after a single request pulse.
// Ports:
//   clk  : system clock, also the ICAP clock
//   rst  : synchronous active-high reset
//   bus  : icap_reboot_ctrl_if.slave (request, status, ICAP write port)
// Optional macro ICAP_REBOOT_WDT_EN adds a watchdog (WDT_CYCLES, wdt_kick,
// wdt_expired) that triggers a reboot into FALLBACK_ADDR when not kicked.
// ADDR_W must be 24; the command words carry exactly 24 address bits.
// ---------------------------------------------------------------------------
module icap_reboot_ctrl #(
  parameter int unsigned ADDR_W            = 24,
  parameter logic [23:0] DEFAULT_BOOT_ADDR = 24'h010000,
  parameter logic [23:0] FALLBACK_ADDR     = 24'h000000,
  parameter logic [7:0]  SPI_OPCODE        = 8'h0B,
  parameter bit          BITSWAP           = 1'b1,
  parameter int unsigned START_DELAY       = 4
`ifdef ICAP_REBOOT_WDT_EN
  , parameter logic [31:0] WDT_CYCLES      = 32'd100_000_000
`endif
) (
  input logic               clk,
  input logic               rst,
  icap_reboot_ctrl_if.slave bus
);

  localparam int unsigned N_WORDS = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  // Counter is loaded with N-1 so DELAY lasts exactly START_DELAY clocks
  localparam logic [CNT_W-1:0] DLY_LOAD =
    (START_DELAY == 0) ? CNT_W'(0) : CNT_W'(START_DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SEQ   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [23:0]       r_addr;

  logic              w_req;
  logic [23:0]       w_req_addr;
  logic [ADDR_W-1:0] w_boot_addr;
  logic [23:0]       w_sel_addr;
  logic [15:0]       w_word;
  logic [15:0]       w_word_out;

  logic              r_busy;
  logic              r_done;
  logic              r_ce_n;
  logic              r_write_n;
  logic [15:0]       r_din;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_ce_n_nxt;
  logic              w_write_n_nxt;
  logic [15:0]       w_din_nxt;

  // Reverse bit order inside each byte (ICAP_SPARTAN6 data convention)
  function automatic logic [15:0] f_bitswap(input logic [15:0] x);
    logic [15:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i]     = x[7-i];
      y[8 + i] = x[15-i];
    end
    return y;
  endfunction

  assign w_boot_addr = bus.boot_addr;
  assign w_sel_addr  = bus.boot_sel ? 24'(w_boot_addr) : DEFAULT_BOOT_ADDR;

`ifdef ICAP_REBOOT_WDT_EN
  logic [31:0] r_wdt_cnt;
  logic        r_wdt_expired;
  logic        w_wdt_fire;

  // Expiry only counts while idle; a kick in the same cycle suppresses it
  assign w_wdt_fire = (r_state == ST_IDLE) && !bus.wdt_kick &&
                      (r_wdt_cnt == (WDT_CYCLES - 32'd1));

  // Watchdog counter and sticky expiry flag
  always_ff @(posedge clk) begin
    if (rst || bus.wdt_kick) begin
      r_wdt_cnt <= 32'd0;
    end else if ((r_state == ST_IDLE) && !w_wdt_fire) begin
      r_wdt_cnt <= r_wdt_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt_expired <= 1'b0;
    end else if (w_wdt_fire) begin
      r_wdt_expired <= 1'b1;
    end
  end

  assign bus.wdt_expired = r_wdt_expired;

  // External request takes priority over the watchdog in the same cycle
  assign w_req      = bus.reboot_req | w_wdt_fire;
  assign w_req_addr = bus.reboot_req ? w_sel_addr : FALLBACK_ADDR;
`else
  assign w_req      = bus.reboot_req;
  assign w_req_addr = w_sel_addr;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = (START_DELAY == 0) ? ST_SEQ : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (r_cnt == CNT_W'(0)) begin
          w_state_nxt = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (!bus.icap_busy && (r_idx == LAST_IDX)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address latch, delay counter and word index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= 24'd0;
      r_cnt  <= CNT_W'(0);
      r_idx  <= IDX_W'(0);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr <= w_req_addr;
            r_cnt  <= DLY_LOAD;
            r_idx  <= IDX_W'(0);
          end
        end
        ST_DELAY: begin
          if (r_cnt != CNT_W'(0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_SEQ: begin
          // ICAP BUSY stalls the index; the same word is re-presented
          if (!bus.icap_busy) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  // IPROG command word selected by index (unswapped)
  always_comb begin
    w_word = 16'hFFFF;
    case (r_idx)
      4'd0:    w_word = 16'hFFFF;                              // dummy
      4'd1:    w_word = 16'hFFFF;                              // dummy
      4'd2:    w_word = 16'hAA99;                              // sync
      4'd3:    w_word = 16'h5566;                              // sync
      4'd4:    w_word = 16'h3261;                              // GENERAL1
      4'd5:    w_word = r_addr[15:0];
      4'd6:    w_word = 16'h3281;                              // GENERAL2
      4'd7:    w_word = {SPI_OPCODE, r_addr[23:16]};
      4'd8:    w_word = 16'h32A1;                              // GENERAL3
      4'd9:    w_word = FALLBACK_ADDR[15:0];
      4'd10:   w_word = 16'h32C1;                              // GENERAL4
      4'd11:   w_word = {SPI_OPCODE, FALLBACK_ADDR[23:16]};
      4'd12:   w_word = 16'h30A1;                              // CMD
      4'd13:   w_word = 16'h000E;                              // IPROG
      4'd14:   w_word = 16'h2000;                              // NOP
      4'd15:   w_word = 16'h2000;                              // NOP
      default: w_word = 16'hFFFF;
    endcase
  end

  assign w_word_out = BITSWAP ? f_bitswap(w_word) : w_word;

  // Output decode from the current state; registered below
  always_comb begin
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_ce_n_nxt    = 1'b1;
    w_write_n_nxt = 1'b1;
    w_din_nxt     = 16'hFFFF;
    case (r_state)
      ST_DELAY: begin
        w_busy_nxt = 1'b1;
      end
      ST_SEQ: begin
        w_busy_nxt    = 1'b1;
        w_ce_n_nxt    = 1'b0;
        w_write_n_nxt = 1'b0;
        w_din_nxt     = w_word_out;
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ce_n    <= 1'b1;
      r_write_n <= 1'b1;
      r_din     <= 16'hFFFF;
    end else begin
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_write_n <= w_write_n_nxt;
      r_din     <= w_din_nxt;
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.icap_ce_n    = r_ce_n;
  assign bus.icap_write_n = r_write_n;
  assign bus.icap_din     = r_din;

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icap_reboot_ctrl
// Two controllers (BITSWAP=0 and BITSWAP=1, START_DELAY=4) share one stimulus
// stream; a word-list model checks every ICAP cycle of both.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_icap_reboot_ctrl;

  localparam int unsigned N_DLY    = 4;
  localparam logic [23:0] DEF_ADDR = 24'h010000;
  localparam logic [23:0] FB_ADDR  = 24'h000000;
  localparam logic [7:0]  OPC      = 8'h0B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req;
  logic        sel;
  logic        ibusy;
  logic [23:0] addr;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mw [16];

  always #5 clk = ~clk;

  icap_reboot_ctrl_if #(.ADDR_W(24)) if0 ();
  icap_reboot_ctrl_if #(.ADDR_W(24)) if1 ();

  assign if0.reboot_req = req;
  assign if0.boot_sel   = sel;
  assign if0.boot_addr  = addr;
  assign if0.icap_busy  = ibusy;
  assign if1.reboot_req = req;
  assign if1.boot_sel   = sel;
  assign if1.boot_addr  = addr;
  assign if1.icap_busy  = ibusy;

`ifdef ICAP_REBOOT_WDT_EN
  logic kick;
  assign if0.wdt_kick = kick;
  assign if1.wdt_kick = kick;
`endif

  icap_reboot_ctrl #(
    .BITSWAP(1'b0), .START_DELAY(N_DLY)
`ifdef ICAP_REBOOT_WDT_EN
    , .WDT_CYCLES(32'd20)
`endif
  ) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

  icap_reboot_ctrl #(
    .BITSWAP(1'b1), .START_DELAY(N_DLY)
`ifdef ICAP_REBOOT_WDT_EN
    , .WDT_CYCLES(32'd20)
`endif
  ) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference word list, straight from the IPROG command table
  task automatic build_words(input logic [23:0] a);
    logic [23:0] fb;
    fb = FB_ADDR;
    mw = '{16'hFFFF, 16'hFFFF, 16'hAA99, 16'h5566,
           16'h3261, a[15:0],  16'h3281, {OPC, a[23:16]},
           16'h32A1, fb[15:0], 16'h32C1, {OPC, fb[23:16]},
           16'h30A1, 16'h000E, 16'h2000, 16'h2000};
  endtask

  // Bit b of the word lands at mirrored position within its own byte
  function automatic logic [15:0] bswap(input logic [15:0] x);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[(b / 8) * 8 + (7 - (b % 8))] = x[b];
    return r;
  endfunction

  task automatic chk_idle(input string tag, input logic exp_busy, input logic exp_done);
    chk({tag, " ce_n0"}, 32'(if0.icap_ce_n), 32'd1);
    chk({tag, " wr_n0"}, 32'(if0.icap_write_n), 32'd1);
    chk({tag, " din0"},  32'(if0.icap_din), 32'hFFFF);
    chk({tag, " ce_n1"}, 32'(if1.icap_ce_n), 32'd1);
    chk({tag, " din1"},  32'(if1.icap_din), 32'hFFFF);
    chk({tag, " busy"},  32'(if0.busy), 32'(exp_busy));
    chk({tag, " done"},  32'(if0.done), 32'(exp_done));
    chk({tag, " done1"}, 32'(if1.done), 32'(exp_done));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One reboot: trigger edge, START_DELAY idle clocks, then every ICAP cycle
  // checked against the list. A word repeats on each clock where BUSY is high.
  task automatic run_seq(input logic [23:0] exp_addr, input bit ext_req,
                         input int stall_p, input int stall_len, input bit rand_busy,
                         input bit noise, input int abort_p, input string name);
    int p, cyc, ce_cnt, stalls, left;
    build_words(exp_addr);
    if (ext_req) req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 0; k < int'(N_DLY); k++) begin
      if (noise) begin
        req  = 1'($urandom_range(0, 1));
        sel  = 1'($urandom_range(0, 1));
        addr = 24'($urandom);
      end
      tick();
      chk_idle({name, " dly"}, 1'b1, 1'b0);
    end
    p = 0; cyc = 0; ce_cnt = 0; stalls = 0; left = stall_len;
    while (p < 16 && cyc < 200 && !(abort_p >= 0 && p == abort_p)) begin
      if (p == stall_p && left > 0) begin
        ibusy = 1'b1;
        left--;
      end else if (rand_busy) begin
        ibusy = ($urandom_range(0, 3) == 0);
      end else begin
        ibusy = 1'b0;
      end
      if (noise) begin
        req  = 1'($urandom_range(0, 1));
        sel  = 1'($urandom_range(0, 1));
        addr = 24'($urandom);
      end
      tick();
      cyc++;
      if (if0.icap_ce_n == 1'b0) ce_cnt++;
      chk({name, " seq ce_n0"}, 32'(if0.icap_ce_n), 32'd0);
      chk({name, " seq wr_n0"}, 32'(if0.icap_write_n), 32'd0);
      chk({name, " seq ce_n1"}, 32'(if1.icap_ce_n), 32'd0);
      chk({name, " seq din0"},  32'(if0.icap_din), 32'(mw[p]));
      chk({name, " seq din1"},  32'(if1.icap_din), 32'(bswap(mw[p])));
      chk({name, " seq busy"},  32'(if0.busy), 32'd1);
      if (ibusy) stalls++;
      else       p++;
    end
    ibusy = 1'b0;
    req   = 1'b0;
    if (abort_p >= 0) begin
      chk({name, " reached abort idx"}, 32'(p), 32'(abort_p));
      rst = 1'b1;
      tick();
      chk_idle({name, " rst"}, 1'b0, 1'b0);
      rst = 1'b0;
    end else begin
      chk({name, " words written"}, 32'(p), 32'd16);
      tick();
      chk_idle({name, " done"}, 1'b0, 1'b1);
      chk({name, " ce cycles"}, 32'(ce_cnt), 32'(16 + stalls));
      if (stall_len > 0 && !rand_busy)
        chk({name, " ce cycles fixed"}, 32'(ce_cnt), 32'(16 + stall_len));
    end
  endtask

  // Requests while DONE must be ignored
  task automatic done_probe(input string name);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    chk_idle({name, " done hold"}, 1'b0, 1'b1);
  endtask

  initial begin
    logic [23:0] ea;
    req = 1'b0; sel = 1'b0; addr = 24'd0; ibusy = 1'b0;
`ifdef ICAP_REBOOT_WDT_EN
    kick = 1'b1;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset", 1'b0, 1'b0);
    rst = 1'b0;
    repeat (5) tick();
    chk_idle("idle", 1'b0, 1'b0);

    // Default address, plain sequence
    sel = 1'b0; addr = 24'hABCDEF;
    run_seq(DEF_ADDR, 1'b1, -1, 0, 1'b0, 1'b0, -1, "t1");
    done_probe("t1");
    do_reset();

    // Runtime address
    sel = 1'b1; addr = 24'h123456;
    run_seq(24'h123456, 1'b1, -1, 0, 1'b0, 1'b0, -1, "t2");
    do_reset();

    // BUSY held three clocks on word 7
    sel = 1'b1; addr = 24'h00BEEF;
    run_seq(24'h00BEEF, 1'b1, 7, 3, 1'b0, 1'b0, -1, "t3");
    do_reset();

    // Reset at word 9, then restart from the top
    sel = 1'b0;
    run_seq(DEF_ADDR, 1'b1, -1, 0, 1'b0, 1'b0, 9, "t4a");
    run_seq(DEF_ADDR, 1'b1, -1, 0, 1'b0, 1'b0, -1, "t4b");
    do_reset();

    // Requests and input changes while running
    sel = 1'b1; addr = 24'h7E5A3C;
    run_seq(24'h7E5A3C, 1'b1, -1, 0, 1'b0, 1'b1, -1, "t5");
    done_probe("t5");
    do_reset();

    // Random addresses and random BUSY
    for (int t = 0; t < 6; t++) begin
      sel  = 1'($urandom_range(0, 1));
      addr = 24'($urandom);
      ea   = sel ? addr : DEF_ADDR;
      run_seq(ea, 1'b1, -1, 0, 1'b1, (t % 2 == 1), -1, "rnd");
      done_probe("rnd");
      do_reset();
    end

`ifdef ICAP_REBOOT_WDT_EN
    // Unkicked watchdog fires on the 20th idle clock into the fallback image
    kick = 1'b1;
    do_reset();
    kick = 1'b0;
    sel = 1'b1; addr = 24'h555555;
    repeat (19) tick();
    chk("wdt early", 32'(if0.wdt_expired), 32'd0);
    chk_idle("wdt early", 1'b0, 1'b0);
    run_seq(FB_ADDR, 1'b0, -1, 0, 1'b0, 1'b0, -1, "wdt");
    chk("wdt expired", 32'(if0.wdt_expired), 32'd1);
    kick = 1'b1;
    do_reset();
    // Regular kicks keep it idle
    for (int i = 0; i < 100; i++) begin
      kick = (i % 10 == 0);
      tick();
    end
    chk("wdt kicked", 32'(if0.wdt_expired), 32'd0);
    chk_idle("wdt kicked", 1'b0, 1'b0);
    kick = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icap_reboot_ctrl.md
Name: icap_reboot_ctrl

Overview:
Parametrised multiboot controller that streams the Spartan-6 IPROG command sequence into an externally instantiated ICAP_SPARTAN6 port. Boot address and fallback address are runtime-selectable. The block honours ICAP BUSY and reports its progress through busy/done status. It sits beside the boot-loader logic and is driven by firmware or a supervisor: a single request pulse reconfigures the FPGA from a chosen flash image.

Parameters:
ADDR_W, 24, flash address width; fixed by the command format, values other than 24 are illegal.
DEFAULT_BOOT_ADDR, 24'h010000, golden/update image address, used when boot_sel=0.
FALLBACK_ADDR, 24'h000000, fallback image address written to General 3/4.
SPI_OPCODE, 8'h0B, SPI read opcode placed in General 2/4 [15:8].
BITSWAP, 1, 1 = bit-reverse each byte of every ICAP word (Spartan-6 ICAP convention); 0 = pass unchanged.
START_DELAY, 4, idle clocks between request acceptance and first CE assertion (0..255).

Ports:
clk  in  1  system clock, also ICAP clock
rst  in  1  synchronous, active-high reset
reboot_req  in  1  single-cycle request pulse
boot_sel  in  1  0 = DEFAULT_BOOT_ADDR, 1 = boot_addr port
boot_addr  in  ADDR_W  runtime boot address, sampled on accepted request
busy  out  1  sequence in progress
done  out  1  full sequence written; sticky until rst
icap_ce_n  out  1  ICAP CE, active low
icap_write_n  out  1  ICAP WRITE, active low
icap_din  out  16  ICAP I data
icap_busy  in  1  ICAP BUSY

Behaviour:
- Reset values: busy=0, done=0, icap_ce_n=1, icap_write_n=1, icap_din=16'hFFFF. Word index=0, FSM=IDLE.
- FSM states: IDLE, DELAY, SEQ, DONE.
- IDLE: reboot_req=1 -> latch addr (boot_sel ? boot_addr : DEFAULT_BOOT_ADDR), load delay counter, busy=1, go to DELAY. If START_DELAY=0, go directly to SEQ.
- DELAY: count down START_DELAY clocks, then go to SEQ. Outputs are held at their idle values.
- SEQ: icap_ce_n=0 and icap_write_n=0 in the same cycle. icap_din = f(word[idx]), where f is the per-byte bit reversal when BITSWAP=1.
- Word index advances by one per clock only when icap_busy=0. When icap_busy=1, idx and the data word are held.
- Word list by idx, unswapped: 0 FFFF; 1 FFFF; 2 AA99; 3 5566; 4 3261; 5 addr[15:0]; 6 3281; 7 {SPI_OPCODE, addr[23:16]}; 8 32A1; 9 FALLBACK_ADDR[15:0]; 10 32C1; 11 {SPI_OPCODE, FALLBACK_ADDR[23:16]}; 12 30A1; 13 000E; 14 2000; 15 2000.
- The sequence has exactly 16 CE-asserted, non-stalled cycles. After idx 15 is accepted: next cycle icap_ce_n=1, icap_write_n=1, state=DONE, busy=0, done=1.
- Latency: with START_DELAY=N and no BUSY, first CE occurs N+1 clocks after the request. done rises 16 clocks after the first CE.
- reboot_req is ignored in DELAY, SEQ and DONE. No queueing. DONE is exited only by rst; in silicon the device reconfigures.
- rst mid-sequence: in the next cycle, CE and WRITE deassert and the FSM returns to IDLE. A partially written sequence is harmless because it lacks IPROG.
- boot_addr/boot_sel changes after acceptance have no effect.

Optional Feature:
ICAP_REBOOT_WDT_EN
- Defined: adds parameter WDT_CYCLES (default 32'd100_000_000), input wdt_kick (1 bit) and output wdt_expired (1 bit, reset 0).
  - A 32-bit counter clears on rst or wdt_kick and increments in IDLE.
  - On reaching WDT_CYCLES-1 in IDLE: wdt_expired=1 (sticky), and an internal request is raised with the addr latched as FALLBACK_ADDR.
  - An external reboot_req in the same cycle as expiry wins.
- Undefined: ports, parameter and counter are absent; behaviour is unchanged.

Test Plan:
- Default params, BITSWAP=0, START_DELAY=4, boot_sel=0, pulse req -> first CE at clock 5. icap_din sequence FFFF, FFFF, AA99, 5566, 3261, 0000, 3281, 0B01, 32A1, 0000, 32C1, 0B00, 30A1, 000E, 2000, 2000. done=1 and busy=0 after 16 CE cycles.
- BITSWAP=1, boot_sel=1, boot_addr=24'h123456 -> word 2 = 5599, word 5 = 2C6A, word 7 = D048, word 13 = 0070.
- Hold icap_busy=1 for 3 clocks while idx=7 -> icap_din and CE are held 3 extra cycles; the total CE-low cycle count is 19.
- Assert rst at idx=9 -> next cycle CE=1, busy=0, done=0. A new req then restarts from FFFF.
- Pulse req during SEQ and again in DONE -> ignored; exactly 16 words are written and done stays 1.
- With ICAP_REBOOT_WDT_EN and WDT_CYCLES=20: no kick -> wdt_expired at cycle 20 and the sequence uses FALLBACK_ADDR. Kicking every 10 cycles -> no sequence is started.
